// File: rtl/icache_sa.sv
// icache_sa: set-associative instruction cache with multi-beat line refill,
// round-robin replacement, whole-cache flush and refill abort on rollback.
module icache_sa #(
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rollback,
    input  logic              flush,
    input  logic [31:0]       MC_val,
    input  logic              MC_val_sgn,
    output logic [ADDR_W-1:0] Mc_addr,
    output logic              Mc_addr_sgn,
    input  logic              pc_change,
    input  logic [ADDR_W-1:0] IF_addr,
    input  logic              IF_addr_sgn,
    output logic [31:0]       IF_val,
    output logic              IF_val_sgn
);
    localparam int OFF   = $clog2(LINE_WORDS) + 2;
    localparam int IDX   = $clog2(SETS);
    localparam int TAG_W = ADDR_W - OFF - IDX;
    localparam int IDX_W = (IDX > 0) ? IDX : 1;
    localparam int WS_W  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;

    // Field extraction by shift-and-mask so degenerate sizes (one word per line) need no empty slices.
    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
        return IDX_W'((a >> OFF) & ADDR_W'(SETS - 1));
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
        return TAG_W'(a >> (OFF + IDX));
    endfunction

    function automatic logic [WS_W-1:0] ws_of(input logic [ADDR_W-1:0] a);
        return WS_W'((a >> 2) & ADDR_W'(LINE_WORDS - 1));
    endfunction

    state_t              state_q, state_d;
    logic [WS_W-1:0]     k_q, k_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [WS_W-1:0]     ws_q, ws_d;
    logic [31:0]         linebuf_q [LINE_WORDS];
    logic [31:0]         linebuf_d [LINE_WORDS];
    logic [WAYS-1:0]     valid_q [SETS];
    logic [WAYS-1:0]     valid_d [SETS];
    logic [WAY_W-1:0]    rr_q [SETS];
    logic [WAY_W-1:0]    rr_d [SETS];
    logic [31:0]         if_val_q, if_val_d;
    logic                if_val_sgn_q, if_val_sgn_d;
    logic [ADDR_W-1:0]   mc_addr_q, mc_addr_d;
    logic                mc_addr_sgn_q, mc_addr_sgn_d;

    logic [TAG_W-1:0]    tag_mem  [SETS][WAYS];
    logic [31:0]         data_mem [SETS][WAYS][LINE_WORDS];

    logic [IDX_W-1:0]    req_idx, fill_idx;
    logic [TAG_W-1:0]    req_tag;
    logic [WS_W-1:0]     req_ws;
    logic                hit, found, fill_en;
    logic [WAY_W-1:0]    hit_way, victim;
    logic [31:0]         hit_word;

    assign req_idx  = idx_of(IF_addr);
    assign req_tag  = tag_of(IF_addr);
    assign req_ws   = ws_of(IF_addr);
    assign fill_idx = idx_of(base_q);
    assign hit_word = data_mem[req_idx][hit_way][req_ws];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && tag_mem[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Lowest-numbered invalid way wins; the round-robin pointer only matters for a full set.
    always_comb begin
        victim = rr_q[fill_idx];
        found  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !valid_q[fill_idx][w]) begin
                victim = WAY_W'(w);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch can be inferred.
        state_d       = state_q;
        k_d           = k_q;
        base_d        = base_q;
        ws_d          = ws_q;
        linebuf_d     = linebuf_q;
        valid_d       = valid_q;
        rr_d          = rr_q;
        if_val_d      = if_val_q;
        if_val_sgn_d  = 1'b0;
        mc_addr_d     = mc_addr_q;
        mc_addr_sgn_d = mc_addr_sgn_q;
        fill_en       = 1'b0;

        if (rdy) begin
            unique case (state_q)
                IDLE: begin
                    if (!rollback && IF_addr_sgn) begin
                        if (hit) begin
                            if (pc_change) begin
                                if_val_d     = hit_word;
                                if_val_sgn_d = 1'b1;
                            end
                        end else begin
                            base_d        = (IF_addr >> OFF) << OFF;
                            ws_d          = req_ws;
                            k_d           = '0;
                            mc_addr_d     = (IF_addr >> OFF) << OFF;
                            mc_addr_sgn_d = 1'b1;
                            state_d       = REFILL;
                        end
                    end
                end
                REFILL: begin
                    if (rollback || flush) begin
                        state_d       = IDLE;
                        k_d           = '0;
                        mc_addr_sgn_d = 1'b0;
                    end else if (MC_val_sgn) begin
                        linebuf_d[k_q] = MC_val;
                        if (k_q == WS_W'(LINE_WORDS - 1)) begin
                            fill_en                   = 1'b1;
                            valid_d[fill_idx][victim] = 1'b1;
                            rr_d[fill_idx]            = (WAYS == 1) ? '0 : rr_q[fill_idx] + WAY_W'(1);
                            k_d                       = '0;
                            mc_addr_sgn_d             = 1'b0;
                            state_d                   = RESP;
                        end else begin
                            k_d       = k_q + WS_W'(1);
                            mc_addr_d = mc_addr_q + ADDR_W'(4);
                        end
                    end
                end
                RESP: begin
                    if (!rollback) begin
                        if_val_d     = linebuf_q[ws_q];
                        if_val_sgn_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase

            if (flush) begin
                for (int s = 0; s < SETS; s++) valid_d[s] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q       <= IDLE;
            k_q           <= '0;
            base_q        <= '0;
            ws_q          <= '0;
            if_val_q      <= '0;
            if_val_sgn_q  <= 1'b0;
            mc_addr_q     <= '0;
            mc_addr_sgn_q <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
            for (int i = 0; i < LINE_WORDS; i++) linebuf_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            base_q        <= base_d;
            ws_q          <= ws_d;
            linebuf_q     <= linebuf_d;
            valid_q       <= valid_d;
            rr_q          <= rr_d;
            if_val_q      <= if_val_d;
            if_val_sgn_q  <= if_val_sgn_d;
            mc_addr_q     <= mc_addr_d;
            mc_addr_sgn_q <= mc_addr_sgn_d;
        end
    end

    // NOTE: tag and data arrays carry no reset; the valid bits alone make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[fill_idx][victim] <= tag_of(base_q);
            for (int i = 0; i < LINE_WORDS; i++) data_mem[fill_idx][victim][i] <= linebuf_d[i];
        end
    end

    assign IF_val      = if_val_q;
    assign IF_val_sgn  = if_val_sgn_q;
    assign Mc_addr     = mc_addr_q;
    assign Mc_addr_sgn = mc_addr_sgn_q;
endmodule

// File: tb/tb_icache_sa.sv
// Directed bench for icache_sa: a set/way cache model predicts every response and
// refill request; a negedge compare process checks the DUT each cycle.
module tb_icache_sa;
    logic        clk = 1'b0;
    logic        rst;
    logic        rdy, rollback, flush, pc_change;
    logic [31:0] MC_val, IF_addr, IF_val, Mc_addr;
    logic        MC_val_sgn, IF_addr_sgn, IF_val_sgn, Mc_addr_sgn;

    int n_tests = 0;
    int n_fail  = 0;

    logic        chk_en      = 1'b0;
    logic        exp_if_sgn  = 1'b0;
    logic [31:0] exp_if_val  = '0;
    logic        exp_mc_sgn  = 1'b0;
    logic [31:0] exp_mc_addr = '0;

    // Cache model: 64 sets x 2 ways x 4 words, round-robin pointer per set.
    bit          m_valid [64][2];
    logic [31:0] m_tag   [64][2];
    logic [31:0] m_data  [64][2][4];
    int          m_rr    [64];

    icache_sa #(.WAYS(2), .SETS(64), .LINE_WORDS(4), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .flush(flush),
        .MC_val(MC_val), .MC_val_sgn(MC_val_sgn),
        .Mc_addr(Mc_addr), .Mc_addr_sgn(Mc_addr_sgn),
        .pc_change(pc_change), .IF_addr(IF_addr), .IF_addr_sgn(IF_addr_sgn),
        .IF_val(IF_val), .IF_val_sgn(IF_val_sgn)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("IF_val_sgn", IF_val_sgn, exp_if_sgn);
            if (exp_if_sgn) check("IF_val", IF_val, exp_if_val);
            check("Mc_addr_sgn", Mc_addr_sgn, exp_mc_sgn);
            if (exp_mc_sgn) check("Mc_addr", Mc_addr, exp_mc_addr);
        end
    end

    // Backing memory: 0x100.. -> A0.., 0x500.. -> B0.., 0x900.. -> C0.., 0xD00.. -> D0..
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA0 + 32'(a[11:10]) * 16 + 32'(a[3:2]);
    endfunction

    function automatic void m_lookup(input logic [31:0] a, output bit h, output logic [31:0] w);
        int s = int'((a / 16) % 64);
        h = 1'b0;
        w = '0;
        for (int i = 0; i < 2; i++) begin
            if (m_valid[s][i] && m_tag[s][i] == a / 1024) begin
                h = 1'b1;
                w = m_data[s][i][(a / 4) % 4];
            end
        end
    endfunction

    function automatic void m_fill(input logic [31:0] a, input logic [31:0] l0, input logic [31:0] l1,
                                   input logic [31:0] l2, input logic [31:0] l3);
        int s = int'((a / 16) % 64);
        int v = -1;
        for (int i = 0; i < 2; i++) if (v < 0 && !m_valid[s][i]) v = i;
        if (v < 0) v = m_rr[s];
        m_valid[s][v]   = 1'b1;
        m_tag[s][v]     = a / 1024;
        m_data[s][v][0] = l0;
        m_data[s][v][1] = l1;
        m_data[s][v][2] = l2;
        m_data[s][v][3] = l3;
        m_rr[s]         = (m_rr[s] + 1) % 2;
    endfunction

    function automatic void m_flush();
        for (int s = 0; s < 64; s++) for (int i = 0; i < 2; i++) m_valid[s][i] = 1'b0;
    endfunction

    function automatic void m_reset();
        m_flush();
        for (int s = 0; s < 64; s++) m_rr[s] = 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rdy         = 1'b1;
        rollback    = 1'b0;
        flush       = 1'b0;
        pc_change   = 1'b0;
        IF_addr_sgn = 1'b0;
        MC_val_sgn  = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        m_flush();
    endtask

    // One fetch; on a miss, beats arrive back to back except for an optional 3-cycle rdy=0
    // stall before beat stall_at, or an abort (rollback or flush) on beat abort_at.
    task automatic fetch(input logic [31:0] a, input int stall_at, input int abort_at,
                         input bit abort_flush, output bit was_hit, output logic [31:0] got);
        bit          h;
        logic [31:0] w, base;
        logic [31:0] line [4];
        m_lookup(a, h, w);
        was_hit     = h;
        got         = '0;
        IF_addr     = a;
        IF_addr_sgn = 1'b1;
        pc_change   = 1'b1;
        tick();
        pc_change = 1'b0;
        if (h) begin
            exp_if_sgn  = 1'b1;
            exp_if_val  = w;
            got         = IF_val;
            IF_addr_sgn = 1'b0;
            tick();
            exp_if_sgn = 1'b0;
            return;
        end
        base        = a & ~32'hF;
        exp_mc_sgn  = 1'b1;
        exp_mc_addr = base;
        for (int k = 0; k < 4; k++) begin
            if (k == stall_at) begin
                rdy        = 1'b0;
                MC_val     = 32'hDEAD_BEEF;
                MC_val_sgn = 1'b1;
                repeat (3) tick();
                rdy = 1'b1;
            end
            MC_val     = mem_word(base + 32'(4 * k));
            MC_val_sgn = 1'b1;
            line[k]    = MC_val;
            if (k == abort_at) begin
                if (abort_flush) flush = 1'b1;
                else rollback = 1'b1;
                IF_addr_sgn = 1'b0;
                tick();
                flush      = 1'b0;
                rollback   = 1'b0;
                MC_val_sgn = 1'b0;
                if (abort_flush) m_flush();
                exp_mc_sgn = 1'b0;
                repeat (3) tick();
                return;
            end
            tick();
            if (k < 3) exp_mc_addr = base + 32'(4 * (k + 1));
            else exp_mc_sgn = 1'b0;
        end
        MC_val_sgn = 1'b0;
        m_fill(a, line[0], line[1], line[2], line[3]);
        tick();
        m_lookup(a, h, w);
        exp_if_sgn  = 1'b1;
        exp_if_val  = w;
        got         = IF_val;
        IF_addr_sgn = 1'b0;
        tick();
        exp_if_sgn = 1'b0;
    endtask

    task automatic expect_fetch(input string name, input logic [31:0] a, input bit hit_exp,
                                input logic [31:0] val_exp);
        bit          h;
        logic [31:0] v;
        fetch(a, -1, -1, 1'b0, h, v);
        check({name, "_hit"}, 64'(h), 64'(hit_exp));
        check({name, "_val"}, v, val_exp);
    endtask

    initial begin
        bit          h;
        logic [31:0] v;
        m_reset();
        rst     = 1'b0;
        IF_addr = '0;
        MC_val  = '0;
        idle_inputs();
        #12;
        check("reset_IF_val", IF_val, 32'h0);
        check("reset_IF_val_sgn", IF_val_sgn, 1'b0);
        check("reset_Mc_addr", Mc_addr, 32'h0);
        check("reset_Mc_addr_sgn", Mc_addr_sgn, 1'b0);
        rst = 1'b1;
        tick();
        chk_en = 1'b1;

        expect_fetch("cold_100", 32'h100, 1'b0, 32'hA0);
        expect_fetch("hit_108", 32'h108, 1'b1, 32'hA2);

        expect_fetch("fill_500", 32'h500, 1'b0, 32'hB0);
        expect_fetch("hit_100", 32'h100, 1'b1, 32'hA0);
        expect_fetch("hit_500", 32'h500, 1'b1, 32'hB0);
        expect_fetch("evict_900", 32'h900, 1'b0, 32'hC0);
        expect_fetch("keep_500", 32'h504, 1'b1, 32'hB1);
        expect_fetch("gone_100", 32'h10C, 1'b0, 32'hA3);

        pulse_flush();
        expect_fetch("flushed_100", 32'h100, 1'b0, 32'hA0);
        expect_fetch("flushed_500", 32'h500, 1'b0, 32'hB0);

        fetch(32'h900, -1, 3, 1'b1, h, v);
        check("flush_last_beat_miss", 64'(h), 64'(1'b0));
        expect_fetch("after_flush_900", 32'h900, 1'b0, 32'hC0);

        pulse_flush();
        fetch(32'h100, -1, 3, 1'b0, h, v);
        check("rollback_miss", 64'(h), 64'(1'b0));
        expect_fetch("refetch_100", 32'h100, 1'b0, 32'hA0);

        fetch(32'hD00, 1, -1, 1'b0, h, v);
        check("stall_hit", 64'(h), 64'(1'b0));
        check("stall_val", v, 32'hD0);
        expect_fetch("stall_line_d0c", 32'hD0C, 1'b1, 32'hD3);

        // Asynchronous reset in the middle of a refill.
        pulse_flush();
        IF_addr     = 32'h100;
        IF_addr_sgn = 1'b1;
        pc_change   = 1'b1;
        tick();
        pc_change   = 1'b0;
        exp_mc_sgn  = 1'b1;
        exp_mc_addr = 32'h100;
        MC_val      = 32'hA0;
        MC_val_sgn  = 1'b1;
        tick();
        exp_mc_addr = 32'h104;
        check("pre_rst_Mc_addr", Mc_addr, 32'h104);
        chk_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("async_rst_IF_val_sgn", IF_val_sgn, 1'b0);
        check("async_rst_Mc_addr_sgn", Mc_addr_sgn, 1'b0);
        check("async_rst_Mc_addr", Mc_addr, 32'h0);
        idle_inputs();
        m_reset();
        exp_if_sgn = 1'b0;
        exp_mc_sgn = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        expect_fetch("post_rst_100", 32'h100, 1'b0, 32'hA0);

        tick();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
